phase_measure: RTL and testbench
================================

PHASE_MEASURE -- requirements
Module: phase_measure

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 24'd10_000_000, is the count at which a measurement is abandoned (1 s at 10 MHz CLK_SYS).
REQ-002 Parameter SYNC_STAGES, default 2, minimum 2, is the synchroniser depth applied to each PPS input.
REQ-003 CLK_SYS  input  1  system clock; all logic SHALL be on its rising edge.
REQ-004 CLK_RST  input  1  reset, asynchronous, active-low.
REQ-005 PPS_GPS  input  1  GPS 1PPS, asynchronous to CLK_SYS; reference edge.
REQ-006 PPS_LOCAL  input  1  locally divided oscillator 1PPS, asynchronous; measured edge.
REQ-007 Measure_Phase  output  24  CLK_SYS cycles from GPS edge to local edge; held between updates.
REQ-008 Measure_Done  output  1  single-cycle pulse; Measure_Phase is valid from this cycle on.
REQ-009 Measure_Timeout  output  1  single-cycle pulse coincident with Measure_Done when the measurement timed out.

Function
REQ-010 Each PPS input SHALL pass through SYNC_STAGES flops, then a rising-edge detector producing a one-cycle strobe (gps_rise, loc_rise).
REQ-011 Both inputs SHALL see identical sync and edge-detect latency so the measured difference is unbiased.
REQ-012 FSM states SHALL be IDLE, COUNT, REPORT.
REQ-013 IDLE: gps_rise and loc_rise in the same cycle -> REPORT with result 0; gps_rise alone -> COUNT with counter cleared to 1; loc_rise alone ignored.
REQ-014 COUNT: counter increments by 1 per cycle; loc_rise -> REPORT with result = counter value in that cycle.
REQ-015 COUNT: gps_rise without loc_rise -> counter reloads to 1, no report (reference restarts).
REQ-016 COUNT: gps_rise and loc_rise in the same cycle -> report current counter (local edge wins), then REPORT.
REQ-017 COUNT: counter reaching TIMEOUT_CYCLES -> REPORT with result 24'hFFFFFF and timeout flag set.
REQ-018 REPORT: lasts exactly one cycle; Measure_Phase loaded, Measure_Done=1, Measure_Timeout=flag; next state IDLE.
REQ-019 Edges arriving during REPORT SHALL be dropped.
REQ-020 Counter SHALL be 24 bits and never wrap; timeout precedes overflow.
REQ-021 Measure_Done SHALL never assert on two consecutive cycles.

Reset
REQ-022 On CLK_RST low: state IDLE, counter 0, synchroniser and edge-detect flops 0, Measure_Phase 24'd0, Measure_Done 0, Measure_Timeout 0.
REQ-023 Reset mid-COUNT SHALL abandon the measurement without a Measure_Done pulse.
REQ-024 After reset release, a PPS input already high SHALL NOT generate an edge strobe.

Configuration
REQ-025 Macro PPS_DEGLITCH_EN: when defined, each synchronised PPS SHALL be treated as high only after 4 consecutive high samples, adding 3 cycles equal latency to both paths; pulses shorter than 4 cycles are ignored.
REQ-026 Without PPS_DEGLITCH_EN the synchroniser output feeds the edge detector directly.

Structure
REQ-027 Shared package gpsdo_pkg SHALL hold the FSM state encoding, PHASE_W = 24, and the timeout sentinel 24'hFFFFFF.
REQ-028 Sub-module pps_edge_sync (synchroniser, optional deglitch, edge detect) SHALL be instantiated once per PPS input.

Verification
REQ-029 GPS rise, local rise 1000 cycles later -> one Measure_Done, Measure_Phase = 1000, Measure_Timeout = 0.
REQ-030 Both rise in the same cycle from IDLE -> Measure_Phase = 0, Measure_Done pulse.
REQ-031 GPS rise, no local edge, TIMEOUT_CYCLES = 50 -> Measure_Done and Measure_Timeout together 50 cycles after strobe, Measure_Phase = 24'hFFFFFF.
REQ-032 GPS rise, second GPS rise 200 cycles later, local rise 300 cycles after the second -> single report, Measure_Phase = 300.
REQ-033 CLK_RST low 500 cycles into COUNT, then a fresh GPS/local pair 40 apart -> no pulse during reset, next report = 40.
REQ-034 With PPS_DEGLITCH_EN, 2-cycle GPS glitch followed by valid pair 700 apart -> glitch ignored, Measure_Phase = 700.

Source files
------------

// File: rtl/gpsdo_pkg.sv
// Shared GPSDO definitions: phase width, timeout sentinel, measurement FSM encoding
// and the PPS conditioning latency helper.
package gpsdo_pkg;

  localparam int PHASE_W = 24;
  localparam logic [PHASE_W-1:0] PHASE_TIMEOUT = 24'hFFFFFF;
  localparam int DEGLITCH_LEN = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  // Edges after reset are trusted only once the previous-level flop holds a real sample.
  function automatic int prime_cycles(input int sync_stages, input bit deglitch);
    return sync_stages + 1 + (deglitch ? (DEGLITCH_LEN - 1) : 0);
  endfunction

endpackage

// File: rtl/phase_measure_if.sv
// PPS inputs and phase-measurement results of phase_measure, plus FSM state for debug.
interface phase_measure_if;
  import gpsdo_pkg::*;

  logic               PPS_GPS;
  logic               PPS_LOCAL;
  logic [PHASE_W-1:0] Measure_Phase;
  logic               Measure_Done;
  logic               Measure_Timeout;
  state_t             fsm_state;

  // Measure_Done is a one-cycle valid strobe with no ready: Measure_Timeout qualifies
  // it, and Measure_Phase is valid from the strobe cycle and holds until the next one.
  modport master (
    output PPS_GPS, PPS_LOCAL,
    input  Measure_Phase, Measure_Done, Measure_Timeout, fsm_state
  );

  modport slave (
    input  PPS_GPS, PPS_LOCAL,
    output Measure_Phase, Measure_Done, Measure_Timeout, fsm_state
  );

endinterface

// File: rtl/pps_edge_sync.sv
// PPS conditioning: synchroniser, optional 4-sample deglitch (PPS_DEGLITCH_EN),
// and a rising-edge strobe that stays quiet until the pipeline is primed after reset.
module pps_edge_sync
  import gpsdo_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic rise
);

  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] sync_q;
  logic              sync_out;
  logic              lvl;
  logic              prev_q;
  logic              primed;
  logic [7:0]        fill_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], pin};
  end

  assign sync_out = sync_q[STAGES-1];

`ifdef PPS_DEGLITCH_EN
  localparam int PRIME = prime_cycles(STAGES, 1'b1);

  logic [DEGLITCH_LEN-2:0] hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_q <= '0;
    else        hist_q <= {hist_q[DEGLITCH_LEN-3:0], sync_out};
  end

  // High only when the current and the three previous samples are all high.
  assign lvl = sync_out & (&hist_q);
`else
  localparam int PRIME = prime_cycles(STAGES, 1'b0);

  assign lvl = sync_out;
`endif

  assign primed = (fill_q == 8'(PRIME));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= '0;
      prev_q <= 1'b0;
    end else begin
      if (!primed) fill_q <= fill_q + 8'd1;
      prev_q <= lvl;
    end
  end

  assign rise = lvl & ~prev_q & primed;

endmodule

// File: rtl/phase_measure.sv
// Measures CLK_SYS cycles from the GPS 1PPS edge to the local 1PPS edge.
// Optional PPS_DEGLITCH_EN adds a 4-sample glitch filter to both PPS paths.
module phase_measure
  import gpsdo_pkg::*;
#(
  parameter logic [PHASE_W-1:0] TIMEOUT_CYCLES = 24'd10_000_000,
  parameter int                 SYNC_STAGES    = 2
) (
  input  logic           CLK_SYS,
  input  logic           CLK_RST,
  phase_measure_if.slave bus
);

  logic gps_rise;
  logic loc_rise;

  state_t             state_q, state_n;
  logic [PHASE_W-1:0] count_q, count_n;
  logic [PHASE_W-1:0] phase_q, phase_n;
  logic               flag_q, flag_n;

  // Identical instances keep both paths at the same latency, so the difference is unbiased.
  pps_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_gps (
    .clk   (CLK_SYS),
    .rst_n (CLK_RST),
    .pin   (bus.PPS_GPS),
    .rise  (gps_rise)
  );

  pps_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_loc (
    .clk   (CLK_SYS),
    .rst_n (CLK_RST),
    .pin   (bus.PPS_LOCAL),
    .rise  (loc_rise)
  );

  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      phase_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      count_q <= count_n;
      phase_q <= phase_n;
      flag_q  <= flag_n;
    end
  end

  always_comb begin
    state_n = state_q;
    count_n = count_q;
    phase_n = phase_q;
    flag_n  = flag_q;
    case (state_q)
      ST_IDLE: begin
        count_n = '0;
        flag_n  = 1'b0;
        if (gps_rise && loc_rise) begin
          state_n = ST_REPORT;
          phase_n = '0;
        end else if (gps_rise) begin
          state_n = ST_COUNT;
          count_n = PHASE_W'(1);
        end
      end
      ST_COUNT: begin
        // Local edge wins over a coincident GPS edge; timeout stops the count before it can wrap.
        if (loc_rise) begin
          state_n = ST_REPORT;
          phase_n = count_q;
          flag_n  = 1'b0;
        end else if (count_q >= TIMEOUT_CYCLES) begin
          state_n = ST_REPORT;
          phase_n = PHASE_TIMEOUT;
          flag_n  = 1'b1;
        end else if (gps_rise) begin
          count_n = PHASE_W'(1);
        end else begin
          count_n = count_q + PHASE_W'(1);
        end
      end
      ST_REPORT: begin
        state_n = ST_IDLE;
        count_n = '0;
      end
      default: begin
        state_n = ST_IDLE;
        count_n = '0;
      end
    endcase
  end

  always_comb begin
    bus.Measure_Phase   = phase_q;
    bus.Measure_Done    = (state_q == ST_REPORT);
    bus.Measure_Timeout = (state_q == ST_REPORT) && flag_q;
    bus.fsm_state       = state_q;
  end

endmodule

// File: tb/tb_phase_measure.sv
// Directed bench for phase_measure: main DUT with default timeout, second DUT with a
// 50-cycle timeout; expected phases and latencies are hand-derived from pin timing.
module tb_phase_measure;
  import gpsdo_pkg::*;

  localparam int TMO = 50;
`ifdef PPS_DEGLITCH_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  int n_checks = 0;
  int n_fail   = 0;

  phase_measure_if bus ();
  phase_measure_if tbus ();

  phase_measure dut (
    .CLK_SYS (clk),
    .CLK_RST (rst_n),
    .bus     (bus)
  );

  phase_measure #(.TIMEOUT_CYCLES(24'(TMO))) dut_tmo (
    .CLK_SYS (clk),
    .CLK_RST (rst_n),
    .bus     (tbus)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- result monitor ----------------
  int          done_cnt = 0, tdone_cnt = 0, consec_cnt = 0;
  int          done_cyc = 0, tdone_cyc = 0;
  logic [23:0] last_phase = '0, tlast_phase = '0;
  logic        last_tmo = 1'b0, tlast_tmo = 1'b0;
  logic        prev_done = 1'b0, tprev_done = 1'b0;

  always @(negedge clk) begin
    if (bus.Measure_Done === 1'b1) begin
      done_cnt++;
      done_cyc   = cyc;
      last_phase = bus.Measure_Phase;
      last_tmo   = bus.Measure_Timeout;
      if (prev_done) consec_cnt++;
    end
    prev_done = (bus.Measure_Done === 1'b1);
    if (tbus.Measure_Done === 1'b1) begin
      tdone_cnt++;
      tdone_cyc   = cyc;
      tlast_phase = tbus.Measure_Phase;
      tlast_tmo   = tbus.Measure_Timeout;
      if (tprev_done) consec_cnt++;
    end
    tprev_done = (tbus.Measure_Done === 1'b1);
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_main(input int base, input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt > base) seen = 1'b1;
    end
  endtask

  task automatic wait_tmo(input int base, input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      #1;
      if (tdone_cnt > base) seen = 1'b1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.PPS_GPS = 1'b0;  bus.PPS_LOCAL = 1'b0;
    tbus.PPS_GPS = 1'b0; tbus.PPS_LOCAL = 1'b0;
    rst_n = 1'b0;
    step(3);
    n_checks++;
    if (bus.Measure_Phase !== 24'd0) begin
      n_fail++; $display("FAIL reset_phase: got %0h expected 0", bus.Measure_Phase);
    end
    n_checks++;
    if (bus.Measure_Done !== 1'b0 || bus.Measure_Timeout !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: done %b timeout %b expected 0 0", bus.Measure_Done, bus.Measure_Timeout);
    end
    n_checks++;
    if (bus.fsm_state !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d expected %0d", bus.fsm_state, ST_IDLE);
    end
    n_checks++;
    if (tbus.Measure_Phase !== 24'd0 || tbus.Measure_Done !== 1'b0) begin
      n_fail++; $display("FAIL reset_tmo_dut: phase %0h done %b expected 0 0", tbus.Measure_Phase, tbus.Measure_Done);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(10);
  endtask

  task automatic test_basic();
    int base, e0, e1;
    bit seen;
    base = done_cnt;
    step(1);
    e0 = cyc;
    bus.PPS_GPS = 1'b1;
    step(10);
    bus.PPS_GPS = 1'b0;
    step(990);
    e1 = cyc;
    bus.PPS_LOCAL = 1'b1;
    wait_main(base, 100, seen);
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL basic_done: no Measure_Done within 100 cycles (gps->local %0d)", e1 - e0);
    end
    step(10);
    bus.PPS_LOCAL = 1'b0;
    step(20);
    n_checks++;
    if (last_phase !== 24'd1000) begin
      n_fail++; $display("FAIL basic_phase: got %0d expected 1000", last_phase);
    end
    n_checks++;
    if (last_tmo !== 1'b0) begin
      n_fail++; $display("FAIL basic_timeout: got %b expected 0", last_tmo);
    end
    n_checks++;
    if (done_cyc - e1 != LAT) begin
      n_fail++; $display("FAIL basic_latency: got %0d expected %0d", done_cyc - e1, LAT);
    end
    n_checks++;
    if (done_cnt - base != 1) begin
      n_fail++; $display("FAIL basic_count: got %0d pulses expected 1", done_cnt - base);
    end
  endtask

  task automatic test_same_cycle();
    int base;
    bit seen;
    base = done_cnt;
    step(1);
    bus.PPS_GPS = 1'b1;
    bus.PPS_LOCAL = 1'b1;
    wait_main(base, 50, seen);
    step(10);
    bus.PPS_GPS = 1'b0;
    bus.PPS_LOCAL = 1'b0;
    step(20);
    n_checks++;
    if (!seen || last_phase !== 24'd0) begin
      n_fail++; $display("FAIL same_cycle_phase: seen %b phase %0d expected 1 0", seen, last_phase);
    end
    n_checks++;
    if (done_cnt - base != 1 || last_tmo !== 1'b0) begin
      n_fail++; $display("FAIL same_cycle_count: pulses %0d tmo %b expected 1 0", done_cnt - base, last_tmo);
    end
  endtask

  task automatic test_timeout();
    int base, mbase, e0;
    bit seen;
    base  = tdone_cnt;
    mbase = done_cnt;
    step(1);
    e0 = cyc;
    tbus.PPS_GPS = 1'b1;
    wait_tmo(base, 200, seen);
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL timeout_done: no Measure_Done within 200 cycles");
    end
    step(10);
    tbus.PPS_GPS = 1'b0;
    step(10);
    n_checks++;
    if (tlast_phase !== 24'hFFFFFF || tlast_tmo !== 1'b1) begin
      n_fail++; $display("FAIL timeout_result: phase %0h tmo %b expected ffffff 1", tlast_phase, tlast_tmo);
    end
    n_checks++;
    if (tdone_cyc - e0 != LAT + TMO) begin
      n_fail++; $display("FAIL timeout_latency: got %0d expected %0d", tdone_cyc - e0, LAT + TMO);
    end
    n_checks++;
    if (tdone_cnt - base != 1 || done_cnt != mbase) begin
      n_fail++; $display("FAIL timeout_count: tmo-dut %0d main %0d expected 1 0", tdone_cnt - base, done_cnt - mbase);
    end
  endtask

  task automatic test_restart();
    int base, mid;
    bit seen;
    base = done_cnt;
    step(1);
    bus.PPS_GPS = 1'b1;
    step(10);
    bus.PPS_GPS = 1'b0;
    step(190);
    bus.PPS_GPS = 1'b1;
    step(10);
    bus.PPS_GPS = 1'b0;
    step(290);
    mid = done_cnt;
    bus.PPS_LOCAL = 1'b1;
    wait_main(base, 100, seen);
    step(10);
    bus.PPS_LOCAL = 1'b0;
    step(20);
    n_checks++;
    if (mid != base) begin
      n_fail++; $display("FAIL restart_early: got %0d pulses before local edge expected 0", mid - base);
    end
    n_checks++;
    if (!seen || last_phase !== 24'd300) begin
      n_fail++; $display("FAIL restart_phase: seen %b phase %0d expected 1 300", seen, last_phase);
    end
    n_checks++;
    if (done_cnt - base != 1) begin
      n_fail++; $display("FAIL restart_count: got %0d pulses expected 1", done_cnt - base);
    end
  endtask

  task automatic test_local_only();
    int base;
    base = done_cnt;
    step(1);
    bus.PPS_LOCAL = 1'b1;
    step(10);
    bus.PPS_LOCAL = 1'b0;
    step(40);
    n_checks++;
    if (done_cnt != base || bus.fsm_state !== ST_IDLE) begin
      n_fail++; $display("FAIL local_only: pulses %0d state %0d expected 0 %0d", done_cnt - base, bus.fsm_state, ST_IDLE);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    bit seen;
    base = done_cnt;
    step(1);
    bus.PPS_GPS = 1'b1;
    step(10);
    bus.PPS_GPS = 1'b0;
    step(67);
    bus.PPS_GPS = 1'b1;
    bus.PPS_LOCAL = 1'b1;
    wait_main(base, 50, seen);
    step(10);
    bus.PPS_GPS = 1'b0;
    bus.PPS_LOCAL = 1'b0;
    step(20);
    n_checks++;
    if (!seen || last_phase !== 24'd77) begin
      n_fail++; $display("FAIL coincident_in_count: seen %b phase %0d expected 1 77", seen, last_phase);
    end
    n_checks++;
    if (done_cnt - base != 1) begin
      n_fail++; $display("FAIL coincident_count: got %0d pulses expected 1", done_cnt - base);
    end
  endtask

  task automatic test_reset_mid_count();
    int base;
    bit seen;
    base = done_cnt;
    step(1);
    bus.PPS_GPS = 1'b1;
    step(10);
    bus.PPS_GPS = 1'b0;
    step(490);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.fsm_state !== ST_IDLE || bus.Measure_Phase !== 24'd0) begin
      n_fail++; $display("FAIL midreset_state: state %0d phase %0d expected %0d 0", bus.fsm_state, bus.Measure_Phase, ST_IDLE);
    end
    step(20);
    n_checks++;
    if (done_cnt != base) begin
      n_fail++; $display("FAIL midreset_pulse: got %0d pulses expected 0", done_cnt - base);
    end
    rst_n = 1'b1;
    step(10);
    bus.PPS_GPS = 1'b1;
    step(10);
    bus.PPS_GPS = 1'b0;
    step(30);
    bus.PPS_LOCAL = 1'b1;
    wait_main(base, 50, seen);
    step(10);
    bus.PPS_LOCAL = 1'b0;
    step(20);
    n_checks++;
    if (!seen || last_phase !== 24'd40 || done_cnt - base != 1) begin
      n_fail++; $display("FAIL midreset_next: seen %b phase %0d pulses %0d expected 1 40 1", seen, last_phase, done_cnt - base);
    end
  endtask

  task automatic test_high_at_reset();
    int base;
    base = done_cnt;
    rst_n = 1'b0;
    bus.PPS_GPS = 1'b1;
    step(5);
    rst_n = 1'b1;
    step(20);
    bus.PPS_LOCAL = 1'b1;
    step(10);
    bus.PPS_LOCAL = 1'b0;
    step(40);
    n_checks++;
    if (done_cnt != base || bus.fsm_state !== ST_IDLE) begin
      n_fail++; $display("FAIL high_at_reset: pulses %0d state %0d expected 0 %0d", done_cnt - base, bus.fsm_state, ST_IDLE);
    end
    bus.PPS_GPS = 1'b0;
    step(10);
  endtask

`ifdef PPS_DEGLITCH_EN
  task automatic test_deglitch();
    int base;
    bit seen;
    base = done_cnt;
    step(1);
    bus.PPS_GPS = 1'b1;
    step(2);
    bus.PPS_GPS = 1'b0;
    step(100);
    bus.PPS_LOCAL = 1'b1;
    step(10);
    bus.PPS_LOCAL = 1'b0;
    step(30);
    n_checks++;
    if (done_cnt != base) begin
      n_fail++; $display("FAIL deglitch_glitch: got %0d pulses expected 0", done_cnt - base);
    end
    bus.PPS_GPS = 1'b1;
    step(10);
    bus.PPS_GPS = 1'b0;
    step(690);
    bus.PPS_LOCAL = 1'b1;
    wait_main(base, 50, seen);
    step(10);
    bus.PPS_LOCAL = 1'b0;
    step(20);
    n_checks++;
    if (!seen || last_phase !== 24'd700 || done_cnt - base != 1) begin
      n_fail++; $display("FAIL deglitch_pair: seen %b phase %0d pulses %0d expected 1 700 1", seen, last_phase, done_cnt - base);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_same_cycle();
    test_timeout();
    test_restart();
    test_local_only();
    test_back_to_back();
    test_reset_mid_count();
    test_high_at_reset();
`ifdef PPS_DEGLITCH_EN
    test_deglitch();
`endif
    n_checks++;
    if (consec_cnt != 0) begin
      n_fail++; $display("FAIL done_consecutive: got %0d back-to-back pulses expected 0", consec_cnt);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
